// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode VGA path: screen geometry,
// RAM widths and the VRAM arbiter state encoding.
package vga_text_pkg;
   localparam int COLS   = 80;
   localparam int ROWS   = 30;
   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int CELLS  = COLS * ROWS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      VREAD = 2'd1,
      WRITE = 2'd2,
      VCAP  = 2'd3
   } vram_state_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Write-client handshake bus into the VRAM arbiter: two req/ack clients
// (bit 0 RTC, bit 1 menu) plus the sticky dropped-write flag.
interface vram_arbiter_if
#(
   parameter int ADDR_W = vga_text_pkg::ADDR_W,
   parameter int DATA_W = vga_text_pkg::DATA_W
);
   logic [1:0]        wr_req;
   logic [ADDR_W-1:0] wr_addr0;
   logic [ADDR_W-1:0] wr_addr1;
   logic [DATA_W-1:0] wr_data0;
   logic [DATA_W-1:0] wr_data1;
   logic [1:0]        wr_ack;
   logic              wr_err;

   modport master (
      output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
      input  wr_ack, wr_err
   );

   modport slave (
      input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
      output wr_ack, wr_err
   );
endinterface

// File: rtl/vram_addr_gen.sv
// Pixel coordinate to text-cell address: (y / CHAR_H) * COLS + (x / CHAR_W).
// Purely combinational; also used by the cursor/menu logic.
module vram_addr_gen
   import vga_text_pkg::*;
#(
   parameter int COLS   = vga_text_pkg::COLS,
   parameter int ADDR_W = vga_text_pkg::ADDR_W
) (
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   output logic [ADDR_W-1:0] cell_addr
);
   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] col;

   assign row = ADDR_W'(pixel_y >> $clog2(CHAR_H));
   assign col = ADDR_W'(pixel_x >> $clog2(CHAR_W));

   generate
      if (COLS == 80) begin : g_shift_add
         // 80 = 64 + 16, keeps the path to two adders
         assign cell_addr = (row << 6) + (row << 4) + col;
      end else begin : g_mul
         assign cell_addr = ADDR_W'(row * COLS) + col;
      end
   endgenerate
endmodule

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: absolute video read slot on pixel_tick,
// remaining cycles shared round-robin between two write clients.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | memory idle
// VREAD | video read in flight on the RAM port
// WRITE | client write on the RAM port
// VCAP  | capture mem_rdata into vid_char (port free for a write)
module vram_arbiter
   import vga_text_pkg::*;
#(
   parameter int COLS   = vga_text_pkg::COLS,
   parameter int ROWS   = vga_text_pkg::ROWS,
   parameter int ADDR_W = vga_text_pkg::ADDR_W,
   parameter int DATA_W = vga_text_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pixel_tick,
   input  logic              video_on,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   vram_arbiter_if.slave     wr_if,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] vid_char,
   output logic              vid_valid
);
   localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(COLS * ROWS);

   vram_state_t       state_q, state_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        wr_ack_q, wr_ack_d;
   logic              wr_err_q, wr_err_d;
   logic [DATA_W-1:0] vid_char_q, vid_char_d;
   logic              vid_valid_q, vid_valid_d;
   logic              rr_q, rr_d;

   logic              vid_slot;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] vid_addr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   vram_addr_gen #(.COLS(COLS), .ADDR_W(ADDR_W)) u_addr_gen (
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .cell_addr (vid_addr)
   );

   assign vid_slot = pixel_tick & video_on;

   // rr_q = 1 means client 1 wins a tie
   always_comb begin
      gnt = 2'b00;
      if (!vid_slot) begin
         case (wr_if.wr_req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign sel_addr = gnt[1] ? wr_if.wr_addr1 : wr_if.wr_addr0;
   assign sel_data = gnt[1] ? wr_if.wr_data1 : wr_if.wr_data0;

   always_comb begin
      state_d     = IDLE;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wr_ack_d    = 2'b00;
      wr_err_d    = wr_err_q;
      rr_d        = rr_q;
      vid_char_d  = vid_char_q;
      vid_valid_d = 1'b0;

      if (vid_slot) begin
         state_d = VREAD;
      end else if (state_q == VREAD) begin
         state_d = VCAP;
      end else if (|gnt) begin
         state_d = WRITE;
      end

      if (vid_slot) begin
         mem_en_d   = 1'b1;
         mem_addr_d = vid_addr;
      end else if (|gnt) begin
         wr_ack_d = gnt;
         rr_d     = gnt[0];
         // out-of-range writes are acked so the client moves on, but never reach the RAM
         if (sel_addr < CELLS_A) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_data;
         end else begin
            wr_err_d = 1'b1;
         end
      end

      if (state_q == VCAP) begin
         vid_char_d  = mem_rdata;
         vid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_ack_q    <= 2'b00;
         wr_err_q    <= 1'b0;
         rr_q        <= 1'b0;
         vid_char_q  <= '0;
         vid_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wr_ack_q    <= wr_ack_d;
         wr_err_q    <= wr_err_d;
         rr_q        <= rr_d;
         vid_char_q  <= vid_char_d;
         vid_valid_q <= vid_valid_d;
      end
   end

   assign mem_en       = mem_en_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign wr_if.wr_ack = wr_ack_q;
   assign wr_if.wr_err = wr_err_q;
   assign vid_char     = vid_char_q;
   assign vid_valid    = vid_valid_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: table of video fetch vectors plus
// hand-written sequences for priority, round-robin, range and reset cases.
module tb_vram_arbiter;
   import vga_text_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              pixel_tick;
   logic              video_on;
   logic [9:0]        pixel_x;
   logic [9:0]        pixel_y;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] vid_char;
   logic              vid_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

   vram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .pixel_tick (pixel_tick),
      .video_on   (video_on),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .wr_if      (wr_if),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .vid_char   (vid_char),
      .vid_valid  (vid_valid)
   );

   // RAM content is a fixed function of the address
   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], 4'h5};
   endfunction

   always @(posedge clk) begin
      if (reset) mem_rdata <= '0;
      else if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
   end

   typedef struct {
      logic [9:0]  px;
      logic [9:0]  py;
      logic [11:0] addr;
   } vvec_t;

   vvec_t vv [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " mem_en"},    32'(mem_en),       0);
      chk({nm, " mem_we"},    32'(mem_we),       0);
      chk({nm, " mem_addr"},  32'(mem_addr),     0);
      chk({nm, " mem_wdata"}, 32'(mem_wdata),    0);
      chk({nm, " wr_ack"},    32'(wr_if.wr_ack), 0);
      chk({nm, " wr_err"},    32'(wr_if.wr_err), 0);
      chk({nm, " vid_char"},  32'(vid_char),     0);
      chk({nm, " vid_valid"}, 32'(vid_valid),    0);
   endtask

   initial begin
      int acks;
      reset          = 1'b1;
      pixel_tick     = 1'b0;
      video_on       = 1'b0;
      pixel_x        = '0;
      pixel_y        = '0;
      wr_if.wr_req   = 2'b00;
      wr_if.wr_addr0 = '0;
      wr_if.wr_addr1 = '0;
      wr_if.wr_data0 = '0;
      wr_if.wr_data1 = '0;

      vv[0] = '{px: 10'd17,  py: 10'd35,  addr: 12'd162};
      vv[1] = '{px: 10'd0,   py: 10'd0,   addr: 12'd0};
      vv[2] = '{px: 10'd639, py: 10'd479, addr: 12'd2399};
      vv[3] = '{px: 10'd8,   py: 10'd16,  addr: 12'd81};
      vv[4] = '{px: 10'd320, py: 10'd240, addr: 12'd1240};
      vv[5] = '{px: 10'd7,   py: 10'd15,  addr: 12'd0};
      vv[6] = '{px: 10'd100, py: 10'd200, addr: 12'd972};

      #12;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      tick();

      // video fetch: read at T+1, vid_valid/vid_char at T+3
      for (int i = 0; i < 7; i++) begin
         pixel_x    = vv[i].px;
         pixel_y    = vv[i].py;
         video_on   = 1'b1;
         pixel_tick = 1'b1;
         tick();
         pixel_tick = 1'b0;
         chk("vid mem_en",   32'(mem_en),   1);
         chk("vid mem_we",   32'(mem_we),   0);
         chk("vid mem_addr", 32'(mem_addr), 32'(vv[i].addr));
         tick();
         chk("vid early valid", 32'(vid_valid), 0);
         tick();
         chk("vid valid", 32'(vid_valid), 1);
         chk("vid char",  32'(vid_char),  32'(pat(vv[i].addr)));
         tick();
         chk("vid valid pulse", 32'(vid_valid), 0);
      end

      // video priority over a continuously requesting client 0
      pixel_x        = 10'd17;
      pixel_y        = 10'd35;
      wr_if.wr_addr0 = 12'd100;
      wr_if.wr_data0 = 8'h3C;
      wr_if.wr_req   = 2'b01;
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         pixel_tick = (c % 4 == 0);
         tick();
         if (c % 4 == 0) begin
            chk("prio read en",  32'(mem_en),       1);
            chk("prio read we",  32'(mem_we),       0);
            chk("prio no ack",   32'(wr_if.wr_ack), 0);
         end else begin
            chk("prio ack",      32'(wr_if.wr_ack), 1);
            chk("prio write we", 32'(mem_we),       1);
            chk("prio addr",     32'(mem_addr),     100);
            chk("prio wdata",    32'(mem_wdata),    32'h3C);
         end
         if (c >= 4 && wr_if.wr_ack[0]) acks++;
      end
      chk("prio acks per period", 32'(acks), 3);
      pixel_tick   = 1'b0;
      wr_if.wr_req = 2'b00;
      tick();
      tick();
      tick();

      // round-robin in blanking; a tick with video_on=0 leaves the slot free
      reset = 1'b1;
      tick();
      reset          = 1'b0;
      video_on       = 1'b0;
      wr_if.wr_addr0 = 12'd10;
      wr_if.wr_data0 = 8'hA1;
      wr_if.wr_addr1 = 12'd20;
      wr_if.wr_data1 = 8'hB2;
      wr_if.wr_req   = 2'b11;
      for (int c = 0; c < 4; c++) begin
         pixel_tick = (c == 1);
         tick();
         chk("rr ack",   32'(wr_if.wr_ack), (c % 2 == 0) ? 1 : 2);
         chk("rr we",    32'(mem_we),       1);
         chk("rr addr",  32'(mem_addr),     (c % 2 == 0) ? 10 : 20);
         chk("rr wdata", 32'(mem_wdata),    (c % 2 == 0) ? 32'hA1 : 32'hB2);
      end
      pixel_tick   = 1'b0;
      wr_if.wr_req = 2'b00;
      tick();
      chk("blank no en", 32'(mem_en), 0);
      tick();
      chk("blank no valid", 32'(vid_valid), 0);
      tick();
      chk("blank no valid late", 32'(vid_valid), 0);

      // range check and sticky error
      chk("err clear before range", 32'(wr_if.wr_err), 0);
      wr_if.wr_addr0 = 12'd2400;
      wr_if.wr_data0 = 8'h55;
      wr_if.wr_req   = 2'b01;
      tick();
      wr_if.wr_req = 2'b00;
      chk("range ack",    32'(wr_if.wr_ack), 1);
      chk("range no en",  32'(mem_en),       0);
      chk("range err",    32'(wr_if.wr_err), 1);
      tick();
      chk("range ack pulse", 32'(wr_if.wr_ack), 0);
      chk("range err sticky", 32'(wr_if.wr_err), 1);
      wr_if.wr_addr0 = 12'd2399;
      wr_if.wr_data0 = 8'h77;
      wr_if.wr_req   = 2'b01;
      tick();
      wr_if.wr_req = 2'b00;
      chk("edge en",    32'(mem_en),       1);
      chk("edge we",    32'(mem_we),       1);
      chk("edge addr",  32'(mem_addr),     2399);
      chk("edge wdata", 32'(mem_wdata),    32'h77);
      chk("edge ack",   32'(wr_if.wr_ack), 1);
      chk("edge err",   32'(wr_if.wr_err), 1);
      tick();

      // reset right after a grant: pointer must come back favouring client 0
      reset = 1'b1;
      tick();
      reset        = 1'b0;
      wr_if.wr_req = 2'b11;
      tick();
      reset = 1'b1;
      #1;
      chk_all_zero("mid reset");
      wr_if.wr_req = 2'b00;
      tick();
      reset        = 1'b0;
      wr_if.wr_req = 2'b11;
      tick();
      wr_if.wr_req = 2'b00;
      chk("post reset first grant", 32'(wr_if.wr_ack), 1);
      tick();

      // request dropped before a grant: no write, no ack
      wr_if.wr_req = 2'b00;
      tick();
      chk("no req no ack", 32'(wr_if.wr_ack), 0);
      chk("no req no en",  32'(mem_en),       0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
